// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4 : four-requester round-robin arbiter with lock-until-release grants.
//
// A grant is held for as long as the owning agent keeps its request high.
// When the owner drops its request, the next requester in round-robin order
// (starting after the most recent owner) is granted on the same edge, so
// there are no dead cycles between owners.
//
// Optional feature, selected by the macro ARB_TIMEOUT_EN:
//   When defined, an owner that has held the grant for MAX_HOLD consecutive
//   cycles while another agent is waiting is forcibly rotated out, and
//   preempt pulses for one cycle. When undefined, MAX_HOLD is unused and
//   preempt is tied low.
//
// Parameters:
//   MAX_HOLD  : maximum consecutive grant cycles per owner (timeout build), 2..255
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous, active-high reset
//   req[3:0]  : per-agent request, held high while the agent uses the resource
//   gnt[3:0]  : registered one-hot grant, all zero when idle
//   gnt_id    : registered binary index of the owner, 0 when idle
//   gnt_valid : high while any grant is active
//   preempt   : one-cycle pulse when a grant is forcibly rotated
module rr_arbiter_4 #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       gnt_valid,
   output logic       preempt
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] last_q, last_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] gnt_id_q, gnt_id_d;

   logic       owner_req;
   logic [3:0] others;
   logic [3:0] cand;
   logic [2:0] pick;
   logic       new_grant;
   logic       tmo_hit;

   // Round-robin search: candidates are scanned in the order from+1, from+2,
   // from+3, from. The loop runs from lowest to highest priority so that the
   // highest-priority match is the last assignment. Returns {found, index}.
   function automatic logic [2:0] rr_pick(input logic [3:0] c, input logic [1:0] from);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         idx = from + 2'(k);
         if (c[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   // 4-to-2 encoder: bit 0 from agents 1/3, bit 1 from agents 2/3.
   function automatic logic [1:0] enc4(input logic [3:0] oh);
      return {oh[2] | oh[3], oh[1] | oh[3]};
   endfunction

   // While granting, last_q is the current owner.
   assign owner_req = req[last_q];
   assign others    = req & ~(4'b0001 << last_q);
   // The owner bit is excluded while granting; when the owner has dropped req
   // that bit is already zero, and on a timeout it must not win again.
   assign cand      = (state_q == S_GRANT) ? others : req;
   assign pick      = rr_pick(cand, last_q);

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);

   logic [7:0] hold_q, hold_d;
   logic       preempt_q;

   assign tmo_hit = (state_q == S_GRANT) && owner_req && (hold_q == HOLD_MAX) && (|others);

   // Hold counter: clears on every new grant, counts while the owner holds,
   // saturates at MAX_HOLD-1.
   always_comb begin
      hold_d = hold_q;
      if (new_grant) begin
         hold_d = 8'd0;
      end else if ((state_q == S_GRANT) && (hold_q != HOLD_MAX)) begin
         hold_d = hold_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q    <= 8'd0;
         preempt_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         preempt_q <= tmo_hit;
      end
   end

   assign preempt = preempt_q;
`else
   assign tmo_hit = 1'b0;
   assign preempt = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         last_q   <= 2'd3;
         gnt_q    <= 4'b0000;
         gnt_id_q <= 2'd0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      new_grant = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pick[2]) begin
               state_d   = S_GRANT;
               last_d    = pick[1:0];
               new_grant = 1'b1;
            end
         end
         S_GRANT: begin
            if (owner_req && !tmo_hit) begin
               state_d = S_GRANT;
            end else if (pick[2]) begin
               // Handoff (or forced rotation) on the same edge.
               state_d   = S_GRANT;
               last_d    = pick[1:0];
               new_grant = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: grant vector and index derive from the next owner so the
   // three outputs are always mutually consistent.
   always_comb begin
      gnt_d    = 4'b0000;
      if (state_d == S_GRANT) gnt_d = 4'b0001 << last_d;
      gnt_id_d = enc4(gnt_d);
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = (state_q == S_GRANT);

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed scenarios plus randomized
// requests compared every cycle against a behavioural model of the
// arbitration rules.
module tb_rr_arbiter_4;

   localparam int MAX_HOLD = 4;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   logic       preempt;

   int total = 0;
   int bad   = 0;

   // Model state: owner index (-1 = idle), last owner, hold count.
   int m_owner;
   int m_last;
   int m_hold;
   bit m_pre;

   rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic int next_winner(input logic [3:0] r, input int from);
      for (int k = 1; k <= 4; k++) begin
         if (r[(from + k) % 4]) return (from + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_last  = 3;
      m_hold  = 0;
      m_pre   = 0;
   endtask

   task automatic model_edge(input logic [3:0] r);
      int w;
      logic [3:0] oth;
      bit timeout_en;
`ifdef ARB_TIMEOUT_EN
      timeout_en = 1;
`else
      timeout_en = 0;
`endif
      m_pre = 0;
      if (m_owner < 0) begin
         w = next_winner(r, m_last);
         if (w >= 0) begin
            m_owner = w; m_last = w; m_hold = 0;
         end
      end else if (r[m_owner]) begin
         oth = r;
         oth[m_owner] = 1'b0;
         if (timeout_en && m_hold == MAX_HOLD - 1 && oth != 0) begin
            w = next_winner(oth, m_last);
            m_owner = w; m_last = w; m_hold = 0; m_pre = 1;
         end else if (m_hold < MAX_HOLD - 1) begin
            m_hold++;
         end
      end else begin
         w = next_winner(r, m_last);
         if (w < 0) begin
            m_owner = -1;
         end else begin
            m_owner = w; m_last = w; m_hold = 0;
         end
      end
   endtask

   task automatic compare_model(input string tag);
      logic [3:0] eg;
      logic [1:0] eid;
      eg  = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      eid = (m_owner < 0) ? 2'd0 : 2'(m_owner);
      chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
      chk({tag, ".id"}, 32'(gnt_id), 32'(eid));
      chk({tag, ".vld"}, 32'(gnt_valid), 32'(m_owner >= 0));
      chk({tag, ".pre"}, 32'(preempt), 32'(m_pre));
   endtask

   // One clock: model consumes the request sampled at the edge, outputs are
   // checked 1 time unit later.
   task automatic step(input string tag);
      @(posedge clk);
      if (rst) model_reset();
      else model_edge(req);
      #1;
      compare_model(tag);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic async_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk({tag, ".gnt"}, 32'(gnt), 32'h0);
      chk({tag, ".id"}, 32'(gnt_id), 32'h0);
      chk({tag, ".vld"}, 32'(gnt_valid), 32'h0);
      chk({tag, ".pre"}, 32'(preempt), 32'h0);
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] r;
      rst = 1'b1;
      req = 4'b0000;
      model_reset();
      #1;
      chk("por.gnt", 32'(gnt), 32'h0);
      chk("por.vld", 32'(gnt_valid), 32'h0);
      step("rst_hold");
      rst = 1'b0;

      // Reset mid-grant.
      req = 4'b0100;
      step("rmg_grant");
      chk("rmg_gnt_0100", 32'(gnt), 32'h4);
      async_reset("rmg_async");
      req = 4'b1111;
      step("rmg_resume");
      chk("rmg_first_0", 32'(gnt), 32'h1);

      // Fairness: each owner drops req once after holding, order 0,1,2,3,0.
      for (int i = 1; i <= 4; i++) begin
         step("fair_hold");
         step("fair_hold");
         r = 4'b1111;
         r[(i - 1) % 4] = 1'b0;
         req = r;
         step("fair_hand");
         chk("fair_id", 32'(gnt_id), 32'(i % 4));
         req = 4'b1111;
      end

      // Lock: a pending request is ignored until the owner releases.
      req = 4'b0000;
      step("lock_idle");
      req = 4'b0010;
      step("lock_grant");
      chk("lock_gnt_0010", 32'(gnt), 32'h2);
      req = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         step("lock_hold");
         chk("lock_stay", 32'(gnt), 32'h2);
      end
      req = 4'b1000;
      step("lock_hand");
      chk("lock_gnt_1000", 32'(gnt), 32'h8);
      chk("lock_id_3", 32'(gnt_id), 32'h3);

      // Idle return then a fresh grant.
      req = 4'b0000;
      step("idle_ret");
      chk("idle_vld", 32'(gnt_valid), 32'h0);
      req = 4'b0100;
      step("idle_regrant");
      chk("idle_gnt_0100", 32'(gnt), 32'h4);

`ifdef ARB_TIMEOUT_EN
      // Timeout rotation after exactly MAX_HOLD cycles.
      async_reset("tmo_rst");
      req = 4'b0101;
      step("tmo_grant");
      chk("tmo_gnt_0", 32'(gnt), 32'h1);
      for (int i = 1; i < MAX_HOLD; i++) begin
         step("tmo_hold");
         chk("tmo_still_0", 32'(gnt), 32'h1);
         chk("tmo_no_pre", 32'(preempt), 32'h0);
      end
      step("tmo_rot");
      chk("tmo_gnt_2", 32'(gnt), 32'h4);
      chk("tmo_pre", 32'(preempt), 32'h1);
      step("tmo_after");
      chk("tmo_pre_clr", 32'(preempt), 32'h0);
      async_reset("tmo_rst2");
      req = 4'b0001;
      for (int i = 0; i < 3 * MAX_HOLD; i++) begin
         step("tmo_solo");
         chk("tmo_solo_gnt", 32'(gnt), 32'h1);
      end
`endif

      // Randomized traffic: sticky requests with occasional toggles and
      // occasional asynchronous resets.
      req = 4'b0000;
      for (int n = 0; n < 3000; n++) begin
         r = req;
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(3) == 0) r[b] = ~r[b];
         end
         req = r;
         step("rnd");
         if ($urandom_range(299) == 0) async_reset("rnd_rst");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
